busca_instrucao: RTL and testbench

Instruction fetch unit: owns the program counter and drives the address port of `memoria_instrucao`. It tracks the memory's one-cycle synchronous read, queues returned words in a 2-entry buffer, and presents them to decode with a valid/ready handshake. It sits between `memoria_instrucao` and the decode stage and accepts branch redirects from execute.

---
 rtl/busca_pkg.sv | 14 +
 rtl/fila_busca.sv | 60 ++++++
 rtl/busca_instrucao.sv | 101 ++++++++++
 tb/tb_busca_instrucao.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
package busca_pkg;

    localparam int          LARGURA_PALAVRA = 32;
    localparam int          PROF_FILA       = 2;
    localparam logic [31:0] HALT_PALAVRA    = 32'hFFFF_FFFF;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [LARGURA_PALAVRA-1:0] instrucao;
        logic [LARGURA_PALAVRA-1:0] pc;
    } entrada_busca_t;

endpackage

// File: rtl/fila_busca.sv
// Two-entry synchronous FIFO of {instrucao, pc}; clear empties it without
// touching stored data, so the head reads 0 only after reset.
module fila_busca
    import busca_pkg::*;
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                push,
    input  logic                                pop,
    input  logic                                clear,
    input  logic [$bits(entrada_busca_t)-1:0]   dado_in,
    output logic [$bits(entrada_busca_t)-1:0]   dado_out,
    output logic                                vazio,
    output logic                                cheio,
    output logic [1:0]                          ocupacao
);

    entrada_busca_t [PROF_FILA-1:0] mem_q, mem_d;
    logic                           rd_q, rd_d;
    logic [1:0]                     ocup_q, ocup_d;
    logic                           wr_idx;
    logic                           faz_push, faz_pop;

    assign vazio    = (ocup_q == 2'd0);
    assign cheio    = (ocup_q == 2'(PROF_FILA));
    assign ocupacao = ocup_q;
    assign dado_out = mem_q[rd_q];

    // With two slots, the write slot is the read slot offset by the occupancy parity.
    assign wr_idx   = rd_q ^ ocup_q[0];
    assign faz_pop  = pop & ~vazio;
    assign faz_push = push & (~cheio | faz_pop);

    always_comb begin
        mem_d  = mem_q;
        rd_d   = rd_q;
        ocup_d = ocup_q;
        if (clear) begin
            rd_d   = 1'b0;
            ocup_d = 2'd0;
        end else begin
            if (faz_push) mem_d[wr_idx] = entrada_busca_t'(dado_in);
            if (faz_pop)  rd_d = ~rd_q;
            ocup_d = ocup_q + {1'b0, faz_push} - {1'b0, faz_pop};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q  <= '0;
            rd_q   <= 1'b0;
            ocup_q <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            ocup_q <= ocup_d;
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch: PC, one outstanding synchronous read, 2-entry buffer to decode.
// Optional halt-word detection is enabled by defining BUSCA_HALT_EN.
module busca_instrucao
    import busca_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL       = 32'd0,
    parameter int unsigned PROFUNDIDADE_MEM = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endereco,
    input  logic [31:0] instrucao_mem,
    input  logic        desvio,
    input  logic [31:0] alvo,
    input  logic        pronto_dec,
    output logic        valido,
    output logic [31:0] instrucao,
    output logic [31:0] pc_out,
    output logic        parado
);

    localparam logic [31:0] MASCARA = 32'(PROFUNDIDADE_MEM - 1);

    logic [31:0]    pc_q, pc_d;
    logic           em_voo_q, em_voo_d;
    logic [31:0]    pc_voo_q, pc_voo_d;
    logic           parado_q, parado_d;

    logic           fila_vazia;
    logic           unused_cheio;
    logic [1:0]     ocupacao;
    logic           pop, push, emite;
    logic [2:0]     em_uso, limite;
    entrada_busca_t entrada_in, entrada_out;

    assign entrada_in = '{instrucao: instrucao_mem, pc: pc_voo_q};

    fila_busca u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .clear    (desvio),
        .dado_in  (entrada_in),
        .dado_out (entrada_out),
        .vazio    (fila_vazia),
        .cheio    (unused_cheio),
        .ocupacao (ocupacao)
    );

    assign valido    = ~fila_vazia & ~desvio;
    assign pop       = valido & pronto_dec;
    assign push      = em_voo_q & ~parado_q & ~desvio;
    assign instrucao = entrada_out.instrucao;
    assign pc_out    = entrada_out.pc;
    assign endereco  = pc_q;
    assign parado    = parado_q;

    // Issue only if buffered + in-flight words, after this cycle's pop, leave room.
    assign em_uso = {1'b0, ocupacao} + {2'b00, em_voo_q};
    assign limite = 3'd2 + {2'b00, pop};
    assign emite  = ~desvio & ~parado_q & (em_uso < limite);

    always_comb begin
        pc_d     = pc_q;
        em_voo_d = emite;
        pc_voo_d = pc_voo_q;
        if (desvio) begin
            pc_d = alvo & MASCARA;
        end else if (emite) begin
            pc_d     = (pc_q + 32'd1) & MASCARA;
            pc_voo_d = pc_q;
        end
    end

    always_comb begin
        parado_d = 1'b0;
`ifdef BUSCA_HALT_EN
        parado_d = parado_q;
        if (desvio)
            parado_d = 1'b0;
        else if (push && instrucao_mem == HALT_PALAVRA)
            parado_d = 1'b1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= PC_INICIAL & MASCARA;
            em_voo_q <= 1'b0;
            pc_voo_q <= '0;
            parado_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            em_voo_q <= em_voo_d;
            pc_voo_q <= pc_voo_d;
            parado_q <= parado_d;
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: memory model mem[i]=32'h100+i, stream scoreboard.
module tb_busca_instrucao;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        desvio = 1'b0;
    logic [31:0] alvo = '0;
    logic        pronto_dec = 1'b0;
    logic        halt_on = 1'b0;

    logic [31:0] instrucao_mem, instrucao_mem_w;
    logic [31:0] endereco, instrucao, pc_out;
    logic        valido, parado;
    logic [31:0] endereco_w, instrucao_w, pc_out_w;
    logic        valido_w, parado_w;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;

    always #5 clock = ~clock;

    busca_instrucao dut (
        .clock(clock), .reset(reset), .endereco(endereco), .instrucao_mem(instrucao_mem),
        .desvio(desvio), .alvo(alvo), .pronto_dec(pronto_dec), .valido(valido),
        .instrucao(instrucao), .pc_out(pc_out), .parado(parado)
    );

    busca_instrucao #(.PC_INICIAL(32'd254)) dut_w (
        .clock(clock), .reset(reset), .endereco(endereco_w), .instrucao_mem(instrucao_mem_w),
        .desvio(desvio), .alvo(alvo), .pronto_dec(pronto_dec), .valido(valido_w),
        .instrucao(instrucao_w), .pc_out(pc_out_w), .parado(parado_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] i;
        i = a & 32'hFF;
        if (halt_on && i == 32'd5) return 32'hFFFF_FFFF;
        return 32'h100 + i;
    endfunction

    always @(posedge clock) begin
        instrucao_mem   <= mem_word(endereco);
        instrucao_mem_w <= mem_word(endereco_w);
    end

    // One cycle: inputs applied just after the edge, outputs readable 3 ns later.
    task automatic step(input logic d, input logic [31:0] a, input logic r);
        @(posedge clock); #1;
        desvio = d; alvo = a; pronto_dec = r;
        #3;
    endtask

    task automatic test_reset;
        @(posedge clock); #1;
        reset = 1'b1; desvio = 1'b0; alvo = '0; pronto_dec = 1'b1;
        #3;
        checks++;
        if (endereco !== 32'd0 || valido !== 1'b0 || instrucao !== 32'd0 || pc_out !== 32'd0 || parado !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: end=%0d val=%b ins=%h pc=%0d par=%b, want 0 0 0 0 0",
                     endereco, valido, instrucao, pc_out, parado);
        end
        checks++;
        if (endereco_w !== 32'd254) begin
            errors++;
            $display("FAIL reset_pc_inicial: end=%0d, want 254", endereco_w);
        end
        @(posedge clock); #1; reset = 1'b0;
        step(1'b0, '0, 1'b1);
        checks++;
        if (valido !== 1'b0) begin
            errors++;
            $display("FAIL first_latency_c1: valido=%b, want 0", valido);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (valido !== 1'b1 || pc_out !== 32'(k) || instrucao !== mem_word(32'(k))) begin
                errors++;
                $display("FAIL back_to_back k=%0d: val=%b pc=%0d ins=%h, want 1 %0d %h",
                         k, valido, pc_out, instrucao, k, mem_word(32'(k)));
            end
        end
        exp_pc = 32'd10;
    endtask

    task automatic test_stall;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (valido !== 1'b1 || pc_out !== exp_pc) begin
                errors++;
                $display("FAIL stall_hold k=%0d: val=%b pc=%0d, want 1 %0d", k, valido, pc_out, exp_pc);
            end
        end
        checks++;
        if (endereco !== ((exp_pc + 32'd2) & 32'hFF)) begin
            errors++;
            $display("FAIL stall_two_buffered: end=%0d, want %0d", endereco, (exp_pc + 32'd2) & 32'hFF);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (valido !== 1'b1 || pc_out !== exp_pc || instrucao !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL stall_resume k=%0d: val=%b pc=%0d ins=%h, want 1 %0d %h",
                         k, valido, pc_out, instrucao, exp_pc, mem_word(exp_pc));
            end
            exp_pc = (exp_pc + 32'd1) & 32'hFF;
        end
    endtask

    task automatic test_desvio;
        step(1'b1, 32'd40, 1'b1);
        checks++;
        if (valido !== 1'b0) begin
            errors++;
            $display("FAIL desvio_cycle: valido=%b, want 0", valido);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (endereco !== 32'd40 || valido !== 1'b0) begin
            errors++;
            $display("FAIL desvio_n1: end=%0d val=%b, want 40 0", endereco, valido);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (valido !== 1'b0) begin
            errors++;
            $display("FAIL desvio_n2: valido=%b, want 0", valido);
        end
        exp_pc = 32'd40;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (valido !== 1'b1 || pc_out !== exp_pc || instrucao !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL desvio_stream k=%0d: val=%b pc=%0d ins=%h, want 1 %0d %h",
                         k, valido, pc_out, instrucao, exp_pc, mem_word(exp_pc));
            end
            exp_pc = (exp_pc + 32'd1) & 32'hFF;
        end
    endtask

    task automatic test_wrap;
        logic [31:0] wpc;
        @(posedge clock); #1; reset = 1'b1; desvio = 1'b0; pronto_dec = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        step(1'b0, '0, 1'b1);
        wpc = 32'd254;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (valido_w !== 1'b1 || pc_out_w !== wpc || instrucao_w !== (32'h100 + wpc)) begin
                errors++;
                $display("FAIL wrap k=%0d: val=%b pc=%0d ins=%h, want 1 %0d %h",
                         k, valido_w, pc_out_w, instrucao_w, wpc, 32'h100 + wpc);
            end
            wpc = (wpc + 32'd1) & 32'hFF;
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0);
        checks++;
        if (valido !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fill: valido=%b, want 1", valido);
        end
        @(posedge clock); #1; reset = 1'b1; #1;
        checks++;
        if (endereco !== 32'd0 || valido !== 1'b0 || instrucao !== 32'd0 || pc_out !== 32'd0 || parado !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_vals: end=%0d val=%b ins=%h pc=%0d par=%b, want 0 0 0 0 0",
                     endereco, valido, instrucao, pc_out, parado);
        end
        @(posedge clock); #1; reset = 1'b0; pronto_dec = 1'b1;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (valido !== 1'b1 || pc_out !== 32'd0 || instrucao !== 32'h100) begin
            errors++;
            $display("FAIL reset_mid_restart: val=%b pc=%0d ins=%h, want 1 0 100", valido, pc_out, instrucao);
        end
    endtask

    task automatic test_random;
        int since;
        step(1'b1, $urandom, 1'b1);
        exp_pc = alvo & 32'hFF;
        since = 0;
        for (int n = 0; n < 400; n++) begin
            logic        d;
            logic [31:0] a;
            logic        r;
            d = ($urandom_range(0, 19) == 0);
            a = $urandom;
            r = ($urandom_range(0, 9) < 7);
            step(d, a, r);
            checks++;
            if (parado !== 1'b0) begin
                errors++;
                $display("FAIL rand_parado n=%0d: parado=%b, want 0", n, parado);
            end
            if (d) begin
                checks++;
                if (valido !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_desvio n=%0d: valido=%b, want 0", n, valido);
                end
                exp_pc = a & 32'hFF;
                since = 0;
            end else begin
                if (since < 100) since++;
                checks++;
                if (valido !== (since >= 3)) begin
                    errors++;
                    $display("FAIL rand_valido n=%0d: valido=%b, want %b", n, valido, since >= 3);
                end
                if (valido === 1'b1 && r) begin
                    checks++;
                    if (pc_out !== exp_pc || instrucao !== mem_word(exp_pc)) begin
                        errors++;
                        $display("FAIL rand_stream n=%0d: pc=%0d ins=%h, want %0d %h",
                                 n, pc_out, instrucao, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = (exp_pc + 32'd1) & 32'hFF;
                end
            end
        end
    endtask

`ifdef BUSCA_HALT_EN
    task automatic test_halt;
        int entregues;
        halt_on = 1'b1;
        @(posedge clock); #1; reset = 1'b1; desvio = 1'b0; pronto_dec = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        entregues = 0;
        for (int n = 0; n < 20; n++) begin
            step(1'b0, '0, 1'b1);
            if (valido === 1'b1) begin
                checks++;
                if (pc_out !== 32'(entregues) || instrucao !== mem_word(32'(entregues))) begin
                    errors++;
                    $display("FAIL halt_stream n=%0d: pc=%0d ins=%h, want %0d %h",
                             n, pc_out, instrucao, entregues, mem_word(32'(entregues)));
                end
                entregues++;
            end
        end
        checks++;
        if (entregues != 6 || parado !== 1'b1 || valido !== 1'b0) begin
            errors++;
            $display("FAIL halt_stop: delivered=%0d par=%b val=%b, want 6 1 0", entregues, parado, valido);
        end
        step(1'b1, 32'd0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (parado !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear: parado=%b, want 0", parado);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (valido !== 1'b1 || pc_out !== 32'd0 || instrucao !== 32'h100) begin
            errors++;
            $display("FAIL halt_restart: val=%b pc=%0d ins=%h, want 1 0 100", valido, pc_out, instrucao);
        end
        halt_on = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_stall;
        test_desvio;
        test_wrap;
        test_reset_mid;
        test_random;
`ifdef BUSCA_HALT_EN
        test_halt;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
